// File: rtl/lut_mult_pkg.sv
// lut_mult_pkg: shared types and constants for the loadable-constant LUT multiplier
package lut_mult_pkg;
  typedef enum logic [2:0] {UNCFG, FILL, READY, MUL, HOLD} state_t;
  localparam int NIBBLE_W    = 4;
  localparam int LUT_DEPTH   = 16;
  localparam int FILL_CYCLES = 15;
endpackage

// File: rtl/lut_mult_table.sv
// lut_mult_table: 16-entry table of nibble multiples k*A built by repeated addition
module lut_mult_table import lut_mult_pkg::*; #(
  parameter int BIT_WIDTH = 8,
  parameter int NR        = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  fill_start,
  input  logic [BIT_WIDTH-1:0]                  a,
  output logic                                  fill_done,
  input  logic [NR*NIBBLE_W-1:0]                rd_addr,
  output logic [NR*(BIT_WIDTH+NIBBLE_W)-1:0]    rd_data
);
  localparam int TW = BIT_WIDTH + NIBBLE_W;
  localparam int PW = $clog2(LUT_DEPTH);
  logic [TW-1:0]        tbl_q [LUT_DEPTH];
  logic [TW-1:0]        tbl_d [LUT_DEPTH];
  logic [BIT_WIDTH-1:0] a_q, a_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 busy_q, busy_d;
  assign fill_done = busy_q && ptr_q == PW'(FILL_CYCLES);
  // table, latched constant and write pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl_q  <= '{default: '0};
      a_q    <= '0;
      ptr_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      tbl_q  <= tbl_d;
      a_q    <= a_d;
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
    end
  end
  // entry 0 is never written, so it stays 0; entry k = entry k-1 + A, one per cycle
  always_comb begin
    tbl_d  = tbl_q;
    a_d    = a_q;
    ptr_d  = ptr_q;
    busy_d = busy_q;
    if (fill_start) begin
      a_d    = a;
      ptr_d  = PW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      tbl_d[ptr_q] = tbl_q[ptr_q - PW'(1)] + TW'(a_q);
      ptr_d        = ptr_q + PW'(1);
      busy_d       = !fill_done;
    end
  end
  for (genvar g = 0; g < NR; g++) begin : g_rd
    assign rd_data[g*TW +: TW] = tbl_q[rd_addr[g*NIBBLE_W +: NIBBLE_W]];
  end
endmodule

// File: rtl/lut_mult_seq_ctrl.sv
// lut_mult_seq_ctrl: run-time loadable constant multiplier sequencer (LUT_MULT_PARALLEL_EN selects single-cycle lookup)
module lut_mult_seq_ctrl import lut_mult_pkg::*; #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [BIT_WIDTH-1:0]   cfg_a,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH-1:0]   X,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*BIT_WIDTH-1:0] C
);
  localparam int NIB = BIT_WIDTH / NIBBLE_W;
  localparam int TW  = BIT_WIDTH + NIBBLE_W;
  localparam int CW  = 2 * BIT_WIDTH;
`ifdef LUT_MULT_PARALLEL_EN
  localparam int NR  = NIB;
`else
  localparam int NR  = 1;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
`endif
  if (BIT_WIDTH == 0 || BIT_WIDTH % NIBBLE_W != 0) begin : g_width_chk
    $error("BIT_WIDTH must be a nonzero multiple of 4");
  end
  state_t                 state_q, state_d;
  logic [CW-1:0]          acc_q, acc_d;
  logic                   cfg_hs, in_hs, fill_done;
  logic [NR*NIBBLE_W-1:0] rd_addr;
  logic [NR*TW-1:0]       rd_data;
  assign cfg_hs = cfg_valid && cfg_ready;
  assign in_hs  = in_valid && in_ready;
  lut_mult_table #(.BIT_WIDTH(BIT_WIDTH), .NR(NR)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .fill_start(cfg_hs),
    .a         (cfg_a),
    .fill_done (fill_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );
`ifdef LUT_MULT_PARALLEL_EN
  logic [CW-1:0] psum;
  assign rd_addr = X;
  // all nibble lookups of the offered operand summed in one cycle
  always_comb begin
    psum = '0;
    for (int i = 0; i < NIB; i++) psum = psum + (CW'(rd_data[i*TW +: TW]) << (NIBBLE_W * i));
  end
`else
  logic [BIT_WIDTH-1:0] x_q, x_d;
  logic [NW-1:0]        nib_q, nib_d;
  logic [CW-1:0]        term;
  assign rd_addr = x_q[NIBBLE_W*nib_q +: NIBBLE_W];
  assign term    = CW'(rd_data) << (NIBBLE_W * nib_q);
`endif
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNCFG;
      acc_q   <= '0;
`ifndef LUT_MULT_PARALLEL_EN
      x_q     <= '0;
      nib_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
`ifndef LUT_MULT_PARALLEL_EN
      x_q     <= x_d;
      nib_q   <= nib_d;
`endif
    end
  end
  // next state; config wins over an operand in READY, operand is latched so reconfig cannot disturb it
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
`ifndef LUT_MULT_PARALLEL_EN
    x_d     = x_q;
    nib_d   = nib_q;
`endif
    case (state_q)
      UNCFG: state_d = cfg_hs ? FILL : UNCFG;
      FILL:  state_d = fill_done ? READY : FILL;
      READY: begin
        if (cfg_hs) state_d = FILL;
        else if (in_hs) begin
`ifdef LUT_MULT_PARALLEL_EN
          acc_d   = psum;
          state_d = HOLD;
`else
          x_d     = X;
          acc_d   = '0;
          nib_d   = '0;
          state_d = MUL;
`endif
        end
      end
      MUL: begin
`ifdef LUT_MULT_PARALLEL_EN
        state_d = READY;
`else
        acc_d   = acc_q + term;
        nib_d   = nib_q + NW'(1);
        state_d = (nib_q == NW'(NIB - 1)) ? HOLD : MUL;
`endif
      end
      HOLD: begin
`ifdef LUT_MULT_PARALLEL_EN
        if (in_hs) acc_d = psum;
        else if (out_ready) state_d = READY;
`else
        if (out_ready) state_d = READY;
`endif
      end
      default: state_d = UNCFG;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    cfg_ready = state_q == UNCFG || state_q == READY;
`ifdef LUT_MULT_PARALLEL_EN
    in_ready  = (state_q == READY && !cfg_valid) || (state_q == HOLD && out_ready);
`else
    in_ready  = state_q == READY && !cfg_valid;
`endif
    out_valid = state_q == HOLD;
    C         = acc_q;
  end
endmodule

// File: tb/tb_lut_mult_seq_ctrl.sv
// tb_lut_mult_seq_ctrl: directed self-checking bench for the sequential (default) build
module tb_lut_mult_seq_ctrl;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0, cfg_ready;
  logic [W-1:0] cfg_a = '0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] X = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [2*W-1:0] C;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  x;
    logic [15:0] c;
    int          hold;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  lut_mult_seq_ctrl #(.BIT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_a(cfg_a),
    .in_valid(in_valid), .in_ready(in_ready), .X(X),
    .out_valid(out_valid), .out_ready(out_ready), .C(C)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_cfg_ready"}, cfg_ready, 1);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_c"}, C, 0);
  endtask

  task automatic do_cfg(input logic [7:0] a);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_a = a;
    #1;
    while (!cfg_ready && n < 40) begin step(); n++; end
    chk("cfg_ready_wait", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    cfg_a = ~a;
    chk("fill_cfg_ready", cfg_ready, 0);
    chk("fill_in_ready", in_ready, 0);
    repeat (14) step();
    chk("fill_len_busy", cfg_ready, 0);
    step();
    chk("fill_len_done", cfg_ready, 1);
  endtask

  task automatic do_mul(input logic [7:0] x, input logic [15:0] c, input int hold);
    int n = 0;
    int lat = 0;
    in_valid = 1'b1;
    X = x;
    out_ready = (hold == 0);
    #1;
    while (!in_ready && n < 40) begin step(); n++; end
    chk("in_ready_wait", in_ready, 1);
    step();
    in_valid = 1'b0;
    X = ~x;
    while (!out_valid && lat < 20) begin step(); lat++; end
    chk("latency", lat, 2);
    chk("product", C, c);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_c", C, c);
    end
    out_ready = 1'b1;
    step();
    chk("release", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int prev_a;
    vecs[0]  = '{8'd2,   8'd0,   16'd0,     0};
    vecs[1]  = '{8'd2,   8'd255, 16'd510,   0};
    vecs[2]  = '{8'd255, 8'd255, 16'd65025, 0};
    vecs[3]  = '{8'd0,   8'd200, 16'd0,     0};
    vecs[4]  = '{8'd7,   8'd10,  16'd70,    5};
    vecs[5]  = '{8'd1,   8'd255, 16'd255,   0};
    vecs[6]  = '{8'd15,  8'd17,  16'd255,   2};
    vecs[7]  = '{8'd16,  8'd16,  16'd256,   0};
    vecs[8]  = '{8'd128, 8'd3,   16'd384,   0};
    vecs[9]  = '{8'd200, 8'd100, 16'd20000, 1};
    vecs[10] = '{8'd255, 8'd0,   16'd0,     0};
    vecs[11] = '{8'd9,   8'd9,   16'd81,    0};

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk_reset_outs("reset");

    in_valid = 1'b1;
    X = 8'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("uncfg_in_ready", in_ready, 0);
      chk("uncfg_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    do_cfg(8'd2);
    for (int x = 0; x < 256; x++) do_mul(8'(x), 16'(2 * x), 0);

    prev_a = -1;
    for (int i = 0; i < 12; i++) begin
      if (int'(vecs[i].a) != prev_a) do_cfg(vecs[i].a);
      prev_a = int'(vecs[i].a);
      do_mul(vecs[i].x, vecs[i].c, vecs[i].hold);
    end

    do_cfg(8'd7);
    in_valid = 1'b1;
    X = 8'd10;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    X = 8'd0;
    cfg_valid = 1'b1;
    cfg_a = 8'd1;
    #1;
    chk("mul_cfg_ready", cfg_ready, 0);
    step();
    chk("mul2_cfg_ready", cfg_ready, 0);
    step();
    chk("recfg_valid", out_valid, 1);
    chk("recfg_c", C, 70);
    chk("hold_cfg_ready", cfg_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("recfg_release", out_valid, 0);
    chk("recfg_ready_again", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("recfg_fill", cfg_ready, 0);
    repeat (15) step();
    do_mul(8'd10, 16'd10, 0);

    do_cfg(8'd2);
    cfg_valid = 1'b1;
    cfg_a = 8'd3;
    in_valid = 1'b1;
    X = 8'd4;
    #1;
    chk("prio_in_ready", in_ready, 0);
    chk("prio_cfg_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    chk("prio_fill_len", n, 15);
    do_mul(8'd4, 16'd12, 0);

    cfg_valid = 1'b1;
    cfg_a = 8'd5;
    step();
    cfg_valid = 1'b0;
    repeat (5) step();
    chk("midfill_busy", cfg_ready, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_reset_outs("midfill_rst");

    do_cfg(8'd9);
    in_valid = 1'b1;
    X = 8'd9;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b0;
    chk_reset_outs("midmul_rst");
    step();
    chk("post_rst_out_valid", out_valid, 0);
    do_cfg(8'd9);
    do_mul(8'd9, 16'd81, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
